// File: rtl/alu_mc.sv
// Multi-cycle ALU for the EX stage: single-cycle logic/arith/shift ops plus an
// iterative unsigned multiply and restoring divide, with valid/ready on both sides.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zf,
  output logic             of,
  output logic             dz
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_XNOR = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MULU = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_next;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic             last_iter;

  logic [WIDTH-1:0] mcand, mul_hi, mul_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;

  logic [WIDTH-1:0] divisor, quot, quot_next;
  logic [WIDTH:0]   rem, rem_next;
  logic [WIDTH+1:0] div_shift;
  logic             div_ge;

  logic [WIDTH-1:0] add_res, sub_res, alu_res;
  logic             alu_of;
  logic [SHW-1:0]   shamt;

  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (op == OP_MULU)      state_next = MUL;
          else if (op == OP_DIVU) state_next = DIV;
          else                    state_next = DONE;
        end
      end
      MUL:  if (last_iter) state_next = DONE;
      DIV:  if (last_iter) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign add_res = a + b;
  assign sub_res = a - b;
  assign shamt   = a[SHW-1:0];

  // Single-cycle result and overflow, computed straight from the live operands.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_XNOR: alu_res = ~(a ^ b);
      OP_ADD: begin
        alu_res = add_res;
        alu_of  = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_of  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: add the multiplicand when the current multiplier LSB is set,
  // then shift the whole {carry, hi, lo} window right by one.
  always_comb begin
    mul_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    {mul_hi_next, mul_lo_next} = {mul_sum, mul_lo[WIDTH-1:1]};
  end

  // Restoring step: bring down the next dividend bit and subtract if it fits.
  always_comb begin
    div_shift = {rem, quot[WIDTH-1]};
    div_ge    = (div_shift >= {2'b00, divisor});
    rem_next  = (WIDTH+1)'(div_ge ? (div_shift - {2'b00, divisor}) : div_shift);
    quot_next = {quot[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mcand     <= '0;
      mul_hi    <= '0;
      mul_lo    <= '0;
      divisor   <= '0;
      quot      <= '0;
      rem       <= '0;
      result    <= '0;
      result_hi <= '0;
      zf        <= 1'b0;
      of        <= 1'b0;
      dz        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= CW'(WIDTH);
            mcand   <= a;
            mul_hi  <= '0;
            mul_lo  <= b;
            divisor <= b;
            quot    <= a;
            rem     <= '0;
            if (op != OP_MULU && op != OP_DIVU) begin
              result    <= alu_res;
              result_hi <= '0;
              zf        <= (alu_res == '0);
              of        <= alu_of;
              dz        <= 1'b0;
            end
          end
        end
        MUL: begin
          mul_hi <= mul_hi_next;
          mul_lo <= mul_lo_next;
          cnt    <= cnt - CW'(1);
          if (last_iter) begin
            result    <= mul_lo_next;
            result_hi <= mul_hi_next;
            zf        <= (mul_lo_next == '0);
            of        <= 1'b0;
            dz        <= 1'b0;
          end
        end
        DIV: begin
          rem  <= rem_next;
          quot <= quot_next;
          cnt  <= cnt - CW'(1);
          if (last_iter) begin
            result    <= quot_next;
            result_hi <= rem_next[WIDTH-1:0];
            zf        <= (quot_next == '0);
            of        <= 1'b0;
            dz        <= (divisor == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases, stall, mid-operation reset,
// back-to-back issue and randomized ops against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result, result_hi;
  logic         zf, of, dz;

  int tests = 0;
  int fails = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zf(zf), .of(of), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: plain integer arithmetic on the operation's definition.
  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [31:0] rh,
                                output logic ezf, output logic eof, output logic edz);
    longint sx  = $signed(x);
    longint sy  = $signed(y);
    longint lim = 64'sd2147483647;
    longint s;
    logic [63:0] p;
    r = '0; rh = '0; eof = 1'b0; edz = 1'b0;
    case (o)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x ^ y;
      4'd3:  r = ~(x ^ y);
      4'd4:  begin s = sx + sy; r = x + y; eof = (s > lim) || (s < -lim - 1); end
      4'd5:  begin s = sx - sy; r = x - y; eof = (s > lim) || (s < -lim - 1); end
      4'd6:  r = (x < y) ? 32'd1 : 32'd0;
      4'd8:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd7:  r = y << x[4:0];
      4'd9:  r = y >> x[4:0];
      4'd10: r = 32'($signed(y) >>> x[4:0]);
      4'd11: begin p = 64'(x) * 64'(y); r = p[31:0]; rh = p[63:32]; end
      4'd12: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; rh = x; edz = 1'b1; end
        else begin r = x / y; rh = x % y; end
      end
      default: r = '0;
    endcase
    ezf = (r == 0);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom());
    endcase
  endfunction

  // Present one op in IDLE, then wait (bounded) for out_valid with out_ready low.
  // lat counts posedges from the accept edge inclusive; rdy counts in_ready-high samples while waiting.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output int rdy);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; rdy = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #1;
    tests++;
    if ({in_ready, out_valid, result, result_hi, zf, of, dz} !== {1'b1, 1'b0, 64'h0, 3'b000}) begin
      fails++;
      $display("[TB] FAIL reset_vals: rdy=%b ov=%b res=%h hi=%h zf=%b of=%b dz=%b, expected 1 0 0 0 0 0 0",
               in_ready, out_valid, result, result_hi, zf, of, dz);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_release: rdy=%b ov=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    int lat, rdy;
    issue(4'd4, 32'h7FFF_FFFF, 32'h1, lat, rdy);
    tests++;
    if (lat !== 1 || result !== 32'h8000_0000 || of !== 1'b1 || zf !== 1'b0 || result_hi !== 32'h0) begin
      fails++;
      $display("[TB] FAIL add_ovf: lat=%0d res=%h hi=%h of=%b zf=%b, expected 1 80000000 0 1 0", lat, result, result_hi, of, zf);
    end
    release_out();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL one_valid_cycle: ov=%b rdy=%b, expected 0 1", out_valid, in_ready);
    end
    issue(4'd5, 32'd5, 32'd5, lat, rdy);
    tests++;
    if (lat !== 1 || result !== 32'h0 || zf !== 1'b1 || of !== 1'b0) begin
      fails++;
      $display("[TB] FAIL sub_zero: lat=%0d res=%h zf=%b of=%b, expected 1 0 1 0", lat, result, zf, of);
    end
    release_out();
    issue(4'd8, 32'hFFFF_FFFF, 32'h1, lat, rdy);
    tests++;
    if (result !== 32'd1) begin
      fails++;
      $display("[TB] FAIL slt: res=%h, expected 1", result);
    end
    release_out();
    issue(4'd6, 32'hFFFF_FFFF, 32'h1, lat, rdy);
    tests++;
    if (result !== 32'd0 || zf !== 1'b1) begin
      fails++;
      $display("[TB] FAIL sltu: res=%h zf=%b, expected 0 1", result, zf);
    end
    release_out();
    issue(4'd10, 32'd4, 32'h8000_0000, lat, rdy);
    tests++;
    if (result !== 32'hF800_0000) begin
      fails++;
      $display("[TB] FAIL sra: res=%h, expected f8000000", result);
    end
    release_out();
    issue(4'd7, 32'h21, 32'h1, lat, rdy);
    tests++;
    if (result !== 32'd2) begin
      fails++;
      $display("[TB] FAIL sll_amount: res=%h, expected 2", result);
    end
    release_out();
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rdy);
    tests++;
    if (lat !== 33 || rdy !== 0 || result !== 32'h1 || result_hi !== 32'hFFFF_FFFE || zf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mulu_max: lat=%0d rdy_hi=%0d res=%h hi=%h zf=%b, expected 33 0 1 fffffffe 0",
               lat, rdy, result, result_hi, zf);
    end
    release_out();
    issue(4'd12, 32'd100, 32'd7, lat, rdy);
    tests++;
    if (lat !== 33 || result !== 32'd14 || result_hi !== 32'd2 || dz !== 1'b0) begin
      fails++;
      $display("[TB] FAIL divu_100_7: lat=%0d res=%h hi=%h dz=%b, expected 33 e 2 0", lat, result, result_hi, dz);
    end
    release_out();
    issue(4'd12, 32'd9, 32'd0, lat, rdy);
    tests++;
    if (lat !== 33 || result !== 32'hFFFF_FFFF || result_hi !== 32'd9 || dz !== 1'b1) begin
      fails++;
      $display("[TB] FAIL divu_by_zero: lat=%0d res=%h hi=%h dz=%b, expected 33 ffffffff 9 1", lat, result, result_hi, dz);
    end
    release_out();
    issue(4'd14, 32'h1234, 32'h5678, lat, rdy);
    tests++;
    if (result !== 32'h0 || zf !== 1'b1 || of !== 1'b0 || dz !== 1'b0 || result_hi !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reserved_op: res=%h hi=%h zf=%b of=%b dz=%b, expected 0 0 1 0 0", result, result_hi, zf, of, dz);
    end
    release_out();
  endtask

  task automatic test_stall();
    int lat, rdy;
    issue(4'd4, 32'd3, 32'd4, lat, rdy);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 4'd2; a = $urandom(); b = $urandom();
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd7 || zf !== 1'b0 || of !== 1'b0) begin
        fails++;
        $display("[TB] FAIL stall_hold[%0d]: ov=%b rdy=%b res=%h zf=%b of=%b, expected 1 0 7 0 0",
                 i, out_valid, in_ready, result, zf, of);
      end
    end
    in_valid = 1'b0;
    release_out();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd7) begin
      fails++;
      $display("[TB] FAIL stall_release: ov=%b rdy=%b res=%h, expected 0 1 7", out_valid, in_ready, result);
    end
    issue(4'd2, 32'hFF, 32'h0F, lat, rdy);
    tests++;
    if (lat !== 1 || result !== 32'hF0) begin
      fails++;
      $display("[TB] FAIL after_stall: lat=%0d res=%h, expected 1 f0", lat, result);
    end
    release_out();
  endtask

  task automatic test_reset_mid_mul();
    int lat, rdy;
    issue(4'd4, 32'd1, 32'd1, lat, rdy);
    release_out();
    @(negedge clk);
    op = 4'd11; a = 32'hDEAD_BEEF; b = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, result, result_hi, zf, of, dz} !== {1'b1, 1'b0, 64'h0, 3'b000}) begin
      fails++;
      $display("[TB] FAIL reset_mid_mul: rdy=%b ov=%b res=%h hi=%h zf=%b of=%b dz=%b, expected 1 0 0 0 0 0 0",
               in_ready, out_valid, result, result_hi, zf, of, dz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_mul_release: rdy=%b ov=%b, expected 1 0", in_ready, out_valid);
    end
    issue(4'd0, 32'hF0, 32'h3C, lat, rdy);
    tests++;
    if (lat !== 1 || result !== 32'h30 || result_hi !== 32'h0) begin
      fails++;
      $display("[TB] FAIL and_after_reset: lat=%0d res=%h hi=%h, expected 1 30 0", lat, result, result_hi);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [31:0] q_r[$];
    logic [2:0]  q_f[$];
    logic [31:0] er, eh;
    logic        ezf, eof, edz;
    int          accepts = 0;
    logic [3:0]  o;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      o = 4'($urandom_range(0, 10));
      op = o; a = pick(); b = pick(); in_valid = 1'b1; out_ready = 1'b1;
      if (in_ready) begin
        model(o, a, b, er, eh, ezf, eof, edz);
        q_r.push_back(er);
        q_f.push_back({ezf, eof, edz});
        accepts++;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        tests++;
        if (q_r.size() == 0) begin
          fails++;
          $display("[TB] FAIL b2b_spurious: out_valid=1 with nothing outstanding, expected 0");
        end else begin
          er = q_r.pop_front();
          if (result !== er || {zf, of, dz} !== q_f[0] || result_hi !== 32'h0) begin
            fails++;
            $display("[TB] FAIL b2b_result: res=%h hi=%h flags=%b, expected %h 0 %b", result, result_hi, {zf, of, dz}, er, q_f[0]);
          end
          void'(q_f.pop_front());
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if (accepts !== 20 || q_r.size() !== 0) begin
      fails++;
      $display("[TB] FAIL b2b_throughput: accepts=%0d pending=%0d, expected 20 0", accepts, q_r.size());
    end
  endtask

  task automatic test_random();
    int          lat, rdy, elat;
    logic [3:0]  o;
    logic [31:0] x, y, er, eh;
    logic        ezf, eof, edz;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      x = pick();
      y = pick();
      model(o, x, y, er, eh, ezf, eof, edz);
      elat = (o == 4'd11 || o == 4'd12) ? 33 : 1;
      issue(o, x, y, lat, rdy);
      tests++;
      if (lat !== elat || rdy !== 0 || result !== er || result_hi !== eh || {zf, of, dz} !== {ezf, eof, edz}) begin
        fails++;
        $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: lat=%0d res=%h hi=%h flags=%b, expected %0d %h %h %b",
                 i, o, x, y, lat, result, result_hi, {zf, of, dz}, elat, er, eh, {ezf, eof, edz});
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
